addsub_pipe: RTL and testbench
==============================

# addsub_pipe

Parametrised, pipelined two's-complement adder/subtractor with carry-in, carry-out, signed-overflow and zero flags, and a valid/ready handshake on both sides. It generalises the team's single-cycle 32-bit full-adder into a WIDTH-bit datapath split into STAGES carry-chained chunks, one chunk resolved per stage. It sits in the execute path of the lab datapath, between operand issue and writeback, sustaining one operation per cycle under backpressure.

## Interface
- WIDTH, 32, operand/result width in bits; WIDTH >= STAGES, WIDTH % STAGES == 0
- STAGES, 4, pipeline depth = number of chunks; chunk width C = WIDTH/STAGES
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  operand set present
- in_ready  output  1  block accepts this cycle
- op  input  1  0 = add, 1 = subtract
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (subtract)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts this cycle
- sum  output  WIDTH  result
- cout  output  1  carry-out of MSB (subtract: 1 = no borrow)
- ovf  output  1  signed overflow
- zero  output  1  sum == 0

## Operation
- Add: {cout,sum} = in1 + in2 + cin (WIDTH+1-bit result).
- Subtract: {cout,sum} = in1 + ~in2 + ~cin, i.e. in1 - in2 - cin; cout = 1 iff no borrow.
- ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), B' = in2 (add) or ~in2 (sub).
- zero computed over full WIDTH sum at final stage.
- Stage k (0..STAGES-1) adds chunk k of A and B' plus carry from stage k-1 (stage 0 uses effective carry cin or ~cin); stores C sum bits and chunk carry.
- Not-yet-consumed upper chunks of A/B' travel in skew registers alongside; completed lower sum chunks travel forward in result registers. No chunk adder spans more than C bits.
- Each stage carries a valid bit; all stages advance together on global enable adv = !out_valid || out_ready.
- in_ready = adv (combinational from out_valid/out_ready only; no dependence on in_valid).
- Accept = in_valid && in_ready; stage-0 valid loads accept on adv. Bubbles propagate as invalid stages.
- op, sign bits and MSB-chunk A/B' bits carried per stage as needed for ovf.

## Timing
- Reset (async assert, any cycle): all stage valids, data, sum, cout, ovf, zero forced 0; out_valid = 0; in_ready = 1 the cycle after reset deasserts (adv = 1 when out_valid = 0). Operations in flight are discarded, never emitted.
- Latency: operation accepted at edge n appears on outputs with out_valid = 1 after edge n+STAGES-1 when no stall (STAGES=1: after accept edge).
- Throughput: one operation per cycle while out_ready = 1.
- Stall: out_valid && !out_ready -> adv = 0; no stage moves; sum/flags held stable; in_ready = 0; nothing accepted.
- Bubble: out_valid = 0 and out_ready = 0 still advances (adv = 1), filling internal bubbles.
- Output transfer = out_valid && out_ready at an edge; same edge may load a new output and accept a new input (simultaneous in/out transfer allowed).
- Outputs are registered; no combinational path in1/in2/op/cin -> outputs.

## Test plan
- Add wrap, WIDTH=32, STAGES=4: in1=FFFFFFFF, in2=00000001, cin=0, op=0 -> after 4 edges sum=00000000, cout=1, zero=1, ovf=0.
- Chunk-boundary carry: in1=0000FFFF, in2=00000001, cin=0 -> sum=00010000, cout=0; also in1=7FFFFFFF, in2=00000001 -> sum=80000000, ovf=1.
- Subtract with borrow: op=1, in1=5, in2=7, cin=0 -> sum=FFFFFFFE, cout=0, ovf=0; op=1, in1=7, in2=5, cin=1 -> sum=00000001, cout=1.
- Streaming + backpressure: 8 back-to-back ops, out_ready low for 3 cycles mid-stream -> in_ready low same cycles, outputs held, all 8 results in order, none lost or duplicated.
- Reset mid-operation: assert reset with 3 ops in flight -> out_valid=0 and sum=0 immediately; no stale result after deassert; next op returns correct result after STAGES edges.
- Parameter sweep: WIDTH=8/STAGES=1, WIDTH=8/STAGES=8, WIDTH=64/STAGES=4 with random operands vs reference model (sum, cout, ovf, zero).

Source files
------------

// File: rtl/addsub_pipe_if.sv
// rtl/addsub_pipe_if.sv - operand/result handshake bundle for addsub_pipe
// Purpose: groups the issue-side and writeback-side valid/ready buses.
// Ports (signals):
//   in_valid/in_ready  operand handshake; op (0 add, 1 sub), in1, in2, cin
//   out_valid/out_ready result handshake; sum, cout, ovf, zero
// Modports: master = operand producer / result consumer, slave = the adder.
interface addsub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, op, in1, in2, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, op, in1, in2, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined WIDTH-bit add/subtract with carry, overflow and zero flags
// Purpose: resolves one C = WIDTH/STAGES bit chunk of the carry chain per stage,
//          so the result of an operation accepted at edge n is on the outputs after
//          edge n+STAGES-1. All stages advance together while the output is free.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high clear of all state
//   bus    addsub_pipe_if slave: operands in, result and flags out
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic          clk,
  input  logic          reset,
  addsub_pipe_if.slave  bus
);
  localparam int C = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] CMASK = {WIDTH{1'b1}} >> (WIDTH - C);

  // Per-stage registers. a_q/b_q hold the operand (B already inverted for
  // subtract) so later stages can pick up their chunk; r_q holds the sum chunks
  // resolved so far; c_q is the carry out of the chunk this stage resolved.
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic             ovf_q;
  logic             zero_q;

  // Stage inputs (from the bus for stage 0, from stage k-1 otherwise).
  logic             v_in [STAGES];
  logic             ci   [STAGES];
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] r_in [STAGES];
  logic [WIDTH-1:0] r_nx [STAGES];
  logic [C:0]       cs   [STAGES];

  logic adv;
  logic accept;

  // The whole pipe moves unless a finished result is waiting on the consumer.
  assign adv          = !v_q[STAGES-1] || bus.out_ready;
  assign accept       = bus.in_valid && adv;
  assign bus.in_ready = adv;

  // Subtract is A + ~B + ~borrow, so invert B and the carry-in once at entry.
  assign v_in[0] = accept;
  assign a_in[0] = bus.in1;
  assign b_in[0] = bus.op ? ~bus.in2 : bus.in2;
  assign ci[0]   = bus.op ? ~bus.cin : bus.cin;
  assign r_in[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign v_in[k] = v_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign ci[k]   = c_q[k-1];
      assign r_in[k] = r_q[k-1];
    end

    assign cs[k]   = {1'b0, a_in[k][k*C +: C]} + {1'b0, b_in[k][k*C +: C]} + {{C{1'b0}}, ci[k]};
    assign r_nx[k] = (r_in[k] & ~(CMASK << (k*C))) | (WIDTH'(cs[k][C-1:0]) << (k*C));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end else if (adv) begin
        v_q[k] <= v_in[k];
        c_q[k] <= cs[k][C];
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        r_q[k] <= r_nx[k];
      end
    end
  end

  // Flags need the complete sum, so they are formed as the last chunk lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1]) &&
                (r_nx[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
      zero_q <= (r_nx[STAGES-1] == '0);
    end
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = r_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - directed and parameter-sweep checks for addsub_pipe
module tb_addsub_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  addsub_pipe_if #(.WIDTH(32)) m ();
  addsub_pipe #(.WIDTH(32), .STAGES(4)) dut (.clk(clk), .reset(reset), .bus(m.slave));

  addsub_pipe_if #(.WIDTH(8)) s1 ();
  addsub_pipe #(.WIDTH(8), .STAGES(1)) dut_s1 (.clk(clk), .reset(reset), .bus(s1.slave));
  addsub_pipe_if #(.WIDTH(8)) s2 ();
  addsub_pipe #(.WIDTH(8), .STAGES(8)) dut_s2 (.clk(clk), .reset(reset), .bus(s2.slave));
  addsub_pipe_if #(.WIDTH(64)) s3 ();
  addsub_pipe #(.WIDTH(64), .STAGES(4)) dut_s3 (.clk(clk), .reset(reset), .bus(s3.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic, {sum, cout, ovf, zero}.
  function automatic logic [66:0] ref_model(input int w, input logic o, input logic [63:0] a,
                                            input logic [63:0] b, input logic ci);
    logic [64:0] mask, bx, ax, full;
    logic [63:0] s;
    logic co, ov, z;
    mask = (65'd1 << w) - 65'd1;
    ax   = {1'b0, a} & mask;
    bx   = o ? (~{1'b0, b}) & mask : {1'b0, b} & mask;
    full = ax + bx + {64'd0, (o ? ~ci : ci)};
    s    = full[63:0] & mask[63:0];
    co   = full[w];
    ov   = (ax[w-1] == bx[w-1]) && (s[w-1] != ax[w-1]);
    z    = (s == 64'd0);
    return {s, co, ov, z};
  endfunction

  // One isolated operation on the 32/4 instance; checks latency and all outputs.
  task automatic do_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic [31:0] es, input logic ec, input logic eo,
                       input logic ez);
    int n;
    @(negedge clk);
    m.op = o; m.in1 = a; m.in2 = b; m.cin = ci; m.in_valid = 1'b1; m.out_ready = 1'b1;
    check({tag, "_in_ready"}, m.in_ready, 1);
    @(negedge clk);
    m.in_valid = 1'b0;
    n = 1;
    while (!m.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 4);
    check({tag, "_sum"},  m.sum,  es);
    check({tag, "_cout"}, m.cout, ec);
    check({tag, "_ovf"},  m.ovf,  eo);
    check({tag, "_zero"}, m.zero, ez);
  endtask

  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic [31:0] prev;
  logic [66:0] q1 [$];
  logic [66:0] q2 [$];
  logic [66:0] q3 [$];
  int tx, rx, stale;

  initial begin
    m.in_valid = 0; m.op = 0; m.in1 = 0; m.in2 = 0; m.cin = 0; m.out_ready = 0;
    s1.in_valid = 0; s1.op = 0; s1.in1 = 0; s1.in2 = 0; s1.cin = 0; s1.out_ready = 1;
    s2.in_valid = 0; s2.op = 0; s2.in1 = 0; s2.in2 = 0; s2.cin = 0; s2.out_ready = 1;
    s3.in_valid = 0; s3.op = 0; s3.in1 = 0; s3.in2 = 0; s3.cin = 0; s3.out_ready = 1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", m.out_valid, 0);
    check("rst_sum", m.sum, 0);
    check("rst_flags", {m.cout, m.ovf, m.zero}, 0);
    reset = 1'b0;
    #1 check("rst_in_ready", m.in_ready, 1);

    // Directed vectors
    do_op("add_wrap",  1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    do_op("chunk_cy",  1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
    do_op("pos_ovf",   1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    do_op("neg_ovf",   1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
    do_op("add_cin",   1'b0, 32'h00000001, 32'h00000002, 1'b1, 32'h00000004, 1'b0, 1'b0, 1'b0);
    do_op("sub_borrow",1'b1, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    do_op("sub_bin",   1'b1, 32'h00000007, 32'h00000005, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0);

    // Streaming with a 3-cycle output stall
    for (int i = 0; i < 8; i++) begin
      sa[i] = 32'(i) * 32'h11111111;
      sb[i] = 32'(i) + 32'd1;
    end
    tx = 0; rx = 0; prev = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      m.out_ready = !(cyc >= 6 && cyc <= 8);
      m.op = 1'b0; m.cin = 1'b0;
      m.in_valid = (tx < 8);
      if (tx < 8) begin
        m.in1 = sa[tx];
        m.in2 = sb[tx];
      end
      #1;
      if (!m.out_ready && m.out_valid) begin
        check("stall_in_ready", m.in_ready, 0);
        if (cyc >= 7) check("stall_hold", m.sum, prev);
      end
      if (m.out_valid && m.out_ready) begin
        check("stream_sum", m.sum, (rx < 8) ? {35'd0, sa[rx] + sb[rx]} : 67'hx);
        rx++;
      end
      if (m.in_valid && m.in_ready) tx++;
      prev = m.sum;
    end
    check("stream_sent", tx, 8);
    check("stream_recv", rx, 8);
    m.in_valid = 1'b0;

    // Reset with operations in flight
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m.in_valid = 1'b1; m.op = 1'b0; m.in1 = 32'(i) + 32'd10; m.in2 = 32'd1; m.cin = 1'b0;
      m.out_ready = 1'b0;
    end
    @(negedge clk);
    m.in_valid = 1'b0;
    check("pre_rst_valid", m.out_valid, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", m.out_valid, 0);
    check("mid_rst_sum", m.sum, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m.out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (m.out_valid) stale++;
    end
    check("post_rst_stale", stale, 0);
    do_op("post_rst_op", 1'b0, 32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0);

    // Parameter sweep against the reference model
    for (int cyc = 0; cyc < 50; cyc++) begin
      logic [63:0] a, b;
      logic o, ci;
      @(negedge clk);
      if (s1.out_valid) check("sweep_8x1",  {56'd0, s1.sum, s1.cout, s1.ovf, s1.zero}, (q1.size() > 0) ? q1.pop_front() : 67'hx);
      if (s2.out_valid) check("sweep_8x8",  {56'd0, s2.sum, s2.cout, s2.ovf, s2.zero}, (q2.size() > 0) ? q2.pop_front() : 67'hx);
      if (s3.out_valid) check("sweep_64x4", {s3.sum, s3.cout, s3.ovf, s3.zero},        (q3.size() > 0) ? q3.pop_front() : 67'hx);
      if (cyc < 30) begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        o = 1'($urandom); ci = 1'($urandom);
        s1.in_valid = 1; s1.op = o; s1.in1 = a[7:0];  s1.in2 = b[7:0];  s1.cin = ci;
        s2.in_valid = 1; s2.op = o; s2.in1 = a[15:8]; s2.in2 = b[15:8]; s2.cin = ci;
        s3.in_valid = 1; s3.op = o; s3.in1 = a;       s3.in2 = b;       s3.cin = ci;
        q1.push_back(ref_model(8,  o, {56'd0, a[7:0]},  {56'd0, b[7:0]},  ci));
        q2.push_back(ref_model(8,  o, {56'd0, a[15:8]}, {56'd0, b[15:8]}, ci));
        q3.push_back(ref_model(64, o, a, b, ci));
      end else begin
        s1.in_valid = 0; s2.in_valid = 0; s3.in_valid = 0;
      end
    end
    check("sweep_drain_8x1",  q1.size(), 0);
    check("sweep_drain_8x8",  q2.size(), 0);
    check("sweep_drain_64x4", q3.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
